present_enc_ctrl: RTL and testbench
===================================

# present_enc_ctrl

Iterative PRESENT block-cipher encryption controller. It sequences one addRoundKey, S-box and bit-permutation round per clock over a 64-bit state register and runs the matching on-the-fly key schedule. It accepts plaintext and key through a valid/ready handshake, runs 31 rounds plus the final whitening, and presents the ciphertext through a second valid/ready handshake. The block sits between the host bus adapter and the 64-bit permutation datapath (`p_layer`), which it instantiates, together with a 16-entry 4-bit S-box.

## Interface
- No parameters. Key width is selected by the macro under Configuration.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: plaintext/key offered.
- `in_ready` out 1: block can accept.
- `in_data` in [0:63]: plaintext, index 0 = MSB.
- `in_key` in [0:79] (or [0:127]): key, index 0 = MSB.
- `out_valid` out 1: ciphertext available.
- `out_ready` in 1: consumer accepts.
- `out_data` out [0:63]: ciphertext, registered.
- `busy` out 1: high while in ROUND state.

## Operation
- Three states, with these transitions:
  - IDLE → ROUND on `in_valid && in_ready`.
  - ROUND → DONE after round 31.
  - DONE → IDLE on `out_valid && out_ready`.
- IDLE: `in_ready=1`. On handshake, load `state<=in_data`, `key<=in_key`, `rc<=1` (5-bit round counter).
- ROUND, each cycle:
  - `t = state ^ key[0:63]`.
  - `state <= p_layer(sbox16(t))`, where sbox16 applies the S-box to every nibble.
  - `key <= update(key, rc)`.
  - `rc <= rc+1`.
- S-box (input 0..F): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- 80-bit key update:
  1. Rotate left by 61.
  2. S-box on the top nibble [0:3].
  3. XOR `rc` into bits [60:64] (LSB-numbered bits 19..15).
- Round 31 (`rc==31`):
  - `out_data <= p_layer(sbox16(state ^ key[0:63])) ^ update(key,31)[0:63]`.
  - `out_valid<=1`; go to DONE.
  - `rc` never reaches 32; no wrap-around.
- DONE: `out_data` and `out_valid` are held stable until the handshake. `in_ready=0`.
- `in_valid` while not IDLE is ignored. `in_data` and `in_key` are sampled only on the accepting edge.
- Reset values:
  - State = IDLE; `in_ready=1` after reset.
  - `out_valid=0`, `out_data=0`, `busy=0`, `rc=0`.
  - Internal state and key registers = 0.
- Reset mid-operation (ROUND or DONE): the current block is discarded and no output handshake occurs. The block is IDLE on the next cycle.

## Timing
- Accept at edge E0. Rounds 1..31 occur at edges E1..E31. `out_valid` is high from the cycle after E31, so latency is 31 cycles from the input handshake.
- `busy` is high for exactly 30 full cycles (between E1 and E31, registered with the state).
- With `out_ready` held high, the output handshake occurs at E32. IDLE follows, and the next accept is at E33, giving one block per 33 cycles.
- `out_ready` low stalls DONE indefinitely with no loss of data.
- `in_ready` is a function of state only. No combinational path exists from `in_valid` or `out_ready` to any output.

## Configuration
- `PRESENT_KEY128_EN`, when defined:
  - `in_key` and the key register are [0:127].
  - Key update:
    1. Rotate left by 61.
    2. S-box on nibbles [0:3] and [4:7].
    3. XOR `rc` into bits [61:65] (LSB-numbered bits 66..62).
  - The round key is `key[0:63]`.
- When not defined: PRESENT-80 as above.
- Latency and handshakes are identical in both builds.

## Test plan
- PRESENT-80, pt=0000000000000000, key=0 → `out_data`=5579C1387B228445, with `out_valid` rising 31 cycles after accept.
- PRESENT-80, pt=0, key=FFFFFFFFFFFFFFFFFFFF → E72C46C0F5945049. Then pt=FFFFFFFFFFFFFFFF, key=all-F → 3333DCD3213210D2, back-to-back with `out_ready`=1: second accept 33 cycles after the first.
- Hold `out_ready`=0 for 10 cycles in DONE → `out_data` stable, `in_ready`=0, and `in_valid` pulses with new data do not corrupt the result. Releasing `out_ready` completes the handshake and gives IDLE next cycle.
- Assert `rst` for one cycle at round 15 → next cycle IDLE, `out_valid`=0, `in_ready`=1. A fresh pt=0/key=0 then yields 5579C1387B228445.
- Build with `PRESENT_KEY128_EN`: pt=0, key=0 (128-bit) → 96DB702A2E6900AF. pt=FFFFFFFFFFFFFFFF, key=0 → compare against the reference model, latency 31.

Source files
------------

// File: rtl/present_enc_ctrl.sv
// present_enc_ctrl: iterative PRESENT encryption controller.
// One addRoundKey / S-box / bit-permutation round per clock over a 64-bit
// state register, with the matching on-the-fly key schedule. Plaintext and
// key arrive through a valid/ready handshake; the ciphertext leaves through
// a second valid/ready handshake.
// Optional build macro PRESENT_KEY128_EN selects PRESENT-128 (128-bit key);
// the default build is PRESENT-80.
// Bit numbering: all vectors are LSB = 0, so the most significant bit of
// plaintext, key and ciphertext is the highest index.
module present_enc_ctrl (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
`ifdef PRESENT_KEY128_EN
  input  logic [127:0]  in_key,
`else
  input  logic [79:0]   in_key,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          busy
);

`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
`else
  localparam int KW = 80;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_t;

  // 4-bit PRESENT S-box
  function automatic logic [3:0] sbox4(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0:    r = 4'hC;
      4'h1:    r = 4'h5;
      4'h2:    r = 4'h6;
      4'h3:    r = 4'hB;
      4'h4:    r = 4'h9;
      4'h5:    r = 4'h0;
      4'h6:    r = 4'hA;
      4'h7:    r = 4'hD;
      4'h8:    r = 4'h3;
      4'h9:    r = 4'hE;
      4'hA:    r = 4'hF;
      4'hB:    r = 4'h8;
      4'hC:    r = 4'h4;
      4'hD:    r = 4'h7;
      4'hE:    r = 4'h1;
      4'hF:    r = 4'h2;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // S-box applied to all sixteen nibbles of the state
  function automatic logic [63:0] sbox16(input logic [63:0] x);
    logic [63:0] r;
    r = 64'd0;
    for (int n = 0; n < 16; n++) begin
      r[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return r;
  endfunction

  // PRESENT bit permutation: bit i moves to 16*i mod 63, bit 63 stays put
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 63; i++) begin
      r[(i * 16) % 63] = x[i];
    end
    r[63] = x[63];
    return r;
  endfunction

  // One key-schedule step: rotate left 61, S-box the top nibble(s), XOR round counter
  function automatic logic [KW-1:0] key_update(input logic [KW-1:0] k, input logic [4:0] rc);
    logic [KW-1:0] r;
    r = {k[KW-62:0], k[KW-1:KW-61]};
    r[KW-1:KW-4] = sbox4(r[KW-1:KW-4]);
`ifdef PRESENT_KEY128_EN
    r[KW-5:KW-8] = sbox4(r[KW-5:KW-8]);
    r[66:62]     = r[66:62] ^ rc;
`else
    r[19:15]     = r[19:15] ^ rc;
`endif
    return r;
  endfunction

  fsm_t            fsm_r;
  fsm_t            fsm_nxt_s;
  logic [63:0]     state_r;
  logic [KW-1:0]   key_r;
  logic [4:0]      rc_r;
  logic [63:0]     out_data_r;
  logic            out_valid_r;
  logic            busy_r;
  logic            in_ready_s;

  logic [63:0]     round_in_s;
  logic [63:0]     perm_s;
  logic [KW-1:0]   key_next_s;

  // Round datapath: addRoundKey, S-box layer, permutation and next round key
  always_comb begin
    round_in_s = state_r ^ key_r[KW-1:KW-64];
    perm_s     = p_layer(sbox16(round_in_s));
    key_next_s = key_update(key_r, rc_r);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r <= ST_IDLE;
    end else begin
      fsm_r <= fsm_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      ST_IDLE: begin
        if (in_valid) begin
          fsm_nxt_s = ST_ROUND;
        end else begin
          fsm_nxt_s = ST_IDLE;
        end
      end
      ST_ROUND: begin
        if (rc_r == 5'd31) begin
          fsm_nxt_s = ST_DONE;
        end else begin
          fsm_nxt_s = ST_ROUND;
        end
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) begin
          fsm_nxt_s = ST_IDLE;
        end else begin
          fsm_nxt_s = ST_DONE;
        end
      end
      default: fsm_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register only
  always_comb begin
    in_ready_s = 1'b0;
    case (fsm_r)
      ST_IDLE:  in_ready_s = 1'b1;
      ST_ROUND: in_ready_s = 1'b0;
      ST_DONE:  in_ready_s = 1'b0;
      default:  in_ready_s = 1'b0;
    endcase
  end

  // Load, round iteration, final whitening and output hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= 64'd0;
      key_r       <= {KW{1'b0}};
      rc_r        <= 5'd0;
      out_data_r  <= 64'd0;
      out_valid_r <= 1'b0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (in_valid) begin
            state_r <= in_data;
            key_r   <= in_key;
            rc_r    <= 5'd1;
          end
        end
        ST_ROUND: begin
          state_r <= perm_s;
          key_r   <= key_next_s;
          if (rc_r == 5'd31) begin
            // Last round: fold in the whitening key and hold the counter
            out_data_r  <= perm_s ^ key_next_s[KW-1:KW-64];
            out_valid_r <= 1'b1;
          end else begin
            rc_r <= rc_r + 5'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // busy covers the rounds strictly after the first round edge up to the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (fsm_r == ST_ROUND) && (fsm_nxt_s == ST_ROUND);
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Self-checking bench for present_enc_ctrl: known-answer vectors, randomized
// blocks against a behavioural PRESENT model, latency/busy/throughput timing,
// output stall and mid-operation reset.
// Honours PRESENT_KEY128_EN the same way the design does.
`timescale 1ns/1ps
module tb_present_enc_ctrl;

`ifdef PRESENT_KEY128_EN
  localparam int KW = 128;
  localparam logic [63:0] KAT_ZERO = 64'h96DB702A2E6900AF;
`else
  localparam int KW = 80;
  localparam logic [63:0] KAT_ZERO = 64'h5579C1387B228445;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic [KW-1:0] in_key;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic          busy;

  int  total = 0;
  int  bad   = 0;
  time prev_accept_t = 0;
  time last_accept_t = 0;

  logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_enc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference key schedule step
  function automatic logic [KW-1:0] ref_ks(input logic [KW-1:0] key, input logic [4:0] rc);
    logic [KW-1:0] k;
    k = (key << 61) | (key >> (KW - 61));
    k[KW-1 -: 4] = sb[k[KW-1 -: 4]];
`ifdef PRESENT_KEY128_EN
    k[KW-5 -: 4] = sb[k[KW-5 -: 4]];
    k[66:62] = k[66:62] ^ rc;
`else
    k[19:15] = k[19:15] ^ rc;
`endif
    return k;
  endfunction

  // Reference PRESENT encryption: 31 full rounds then whitening
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [KW-1:0] key);
    logic [63:0]   st;
    logic [63:0]   sub;
    logic [63:0]   nst;
    logic [KW-1:0] k;
    logic [4:0]    rc;
    st = pt;
    k  = key;
    rc = 5'd1;
    for (int r = 1; r <= 31; r++) begin
      st = st ^ k[KW-1 -: 64];
      for (int n = 0; n < 16; n++) sub[4*n +: 4] = sb[st[4*n +: 4]];
      nst = 64'd0;
      for (int b = 0; b < 64; b++) nst[16*(b%4) + b/4] = sub[b];
      st = nst;
      k  = ref_ks(k, rc);
      rc = rc + 5'd1;
    end
    return st ^ k[KW-1 -: 64];
  endfunction

  function automatic logic [KW-1:0] rand_key();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[KW-1:0];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Runs one block; called at a negedge, returns at the negedge after the output handshake
  task automatic run_block(input logic [63:0] pt, input logic [KW-1:0] key,
                           input int stall, input logic [63:0] exp, input string tag);
    int c;
    int bc;
    bit got;
    chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_data   = pt;
    in_key    = key;
    out_ready = (stall == 0);
    @(posedge clk);
    prev_accept_t = last_accept_t;
    last_accept_t = $time;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand64();
    in_key   = rand_key();
    c = 0; bc = 0; got = 1'b0;
    while (!got && c < 40) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (busy) bc++;
      if (out_valid) got = 1'b1;
    end
    chk({tag, "_latency"}, 64'(c), 64'd31);
    chk({tag, "_busy_cycles"}, 64'(bc), 64'd30);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = rand64();
        in_key   = rand_key();
        @(posedge clk);
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_data"}, out_data, exp);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0]   pt;
    logic [KW-1:0] key;
    logic [63:0]   all_f64;
    logic [KW-1:0] all_fk;
    int            ov_cnt;
    all_f64   = '1;
    all_fk    = '1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    in_key    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    run_block(64'd0, '0, 0, KAT_ZERO, "kat_zero");
`ifdef PRESENT_KEY128_EN
    run_block(64'd0, all_fk, 0, ref_enc(64'd0, all_fk), "pt0_keyf");
    run_block(all_f64, '0, 0, ref_enc(all_f64, '0), "ptf_key0");
`else
    run_block(64'd0, all_fk, 0, 64'hE72C46C0F5945049, "pt0_keyf");
    run_block(all_f64, all_fk, 0, 64'h3333DCD3213210D2, "ptf_keyf");
`endif
    chk("b2b_accept_gap", 64'((last_accept_t - prev_accept_t) / 10), 64'd33);

    pt  = rand64();
    key = rand_key();
    run_block(pt, key, 10, ref_enc(pt, key), "stall10");

    // Reset in the middle of the rounds discards the block
    in_valid = 1'b1;
    in_data  = rand64();
    in_key   = rand_key();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    out_ready = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("midrst_no_output", 64'(ov_cnt), 64'd0);
    run_block(64'd0, '0, 0, KAT_ZERO, "after_rst");

    for (int i = 0; i < 6; i++) begin
      pt  = rand64();
      key = rand_key();
      run_block(pt, key, int'($urandom_range(0, 3)), ref_enc(pt, key), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
